// File: rtl/gd_data_buffer.sv
// UART byte-stream bridge: serialises the command packet to the UART TX and
// packs received bytes into a word-wide RAM with a byte count and word read port.
module gd_data_buffer #(
  parameter int unsigned DEPTH_WORDS = 32768,
  parameter int unsigned ADDR_W      = 15,
  parameter int unsigned CMD_BYTES   = 12
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   uart_start,
  input  logic [8*CMD_BYTES-1:0] cmd_buf,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  input  logic                   reset_bytes_transmitted,
  output logic [15:0]            bytes_in,
  input  logic [15:0]            read_addr,
  input  logic                   buffer_read,
  output logic [15:0]            word_in,
  output logic                   busy,
  output logic                   overflow
);

  localparam int unsigned IDX_W = (CMD_BYTES > 1) ? $clog2(CMD_BYTES) : 1;

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t                 state;
  logic                   uart_start_q;
  logic                   start_edge;
  logic [8*CMD_BYTES-1:0] shadow;
  logic [IDX_W-1:0]       idx;

  logic        full;
  logic        we;
  logic [15:0] off;
  logic [15:0] wdata;
  logic [7:0]  hold_hi;
  logic [15:0] mem [DEPTH_WORDS];
  logic        unused_read_bits;

  assign unused_read_bits = ^read_addr[15:ADDR_W];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      uart_start_q <= 1'b0;
      start_edge   <= 1'b0;
    end else begin
      uart_start_q <= uart_start;
      start_edge   <= uart_start & ~uart_start_q;
    end
  end

  // The shadow shifts down one byte per handshake, so the next byte is always shadow[15:8].
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      shadow   <= '0;
      idx      <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_edge) begin
            shadow   <= cmd_buf;
            tx_data  <= cmd_buf[7:0];
            idx      <= '0;
            tx_valid <= 1'b1;
            busy     <= 1'b1;
            state    <= SEND;
          end
        end
        SEND: begin
          if (tx_ready) begin
            if (idx == IDX_W'(CMD_BYTES - 1)) begin
              tx_valid <= 1'b0;
              busy     <= 1'b0;
              state    <= DONE;
            end else begin
              idx     <= idx + IDX_W'(1);
              shadow  <= shadow >> 8;
              tx_data <= shadow[15:8];
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // A clear in the same cycle as a byte restarts the stream at offset 0.
  always_comb begin
    full  = &bytes_in;
    off   = reset_bytes_transmitted ? '0 : bytes_in;
    we    = rx_valid & (reset_bytes_transmitted | ~full);
    wdata = off[0] ? {hold_hi, rx_data} : {rx_data, 8'h00};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bytes_in <= '0;
      overflow <= 1'b0;
      hold_hi  <= '0;
    end else begin
      if (reset_bytes_transmitted) begin
        overflow <= 1'b0;
        bytes_in <= {15'd0, rx_valid};
      end else if (rx_valid) begin
        if (full) overflow <= 1'b1;
        else      bytes_in <= bytes_in + 16'd1;
      end
      if (we && !off[0]) hold_hi <= rx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[off[ADDR_W:1]] <= wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           word_in <= '0;
    else if (buffer_read) word_in <= mem[read_addr[ADDR_W-1:0]];
  end

endmodule

// File: doc/gd_data_buffer.md
# gd_data_buffer

Byte-stream bridge between the UART link and `ide_processor`. On a `uart_start` pulse it serialises the 12-byte SPI command packet to the UART transmitter. Independently, it stores every byte from the UART receiver into a word-wide RAM, maintains the `bytes_in` count, and serves synchronous word reads addressed by `read_addr`. It sits directly upstream of `ide_processor` and drives its `bytes_in` and `word_in` inputs.

## Interface
- `DEPTH_WORDS`, 32768: buffer depth in 16-bit words.
- `ADDR_W`, 15: word address width; `DEPTH_WORDS` = 2**`ADDR_W`.
- `CMD_BYTES`, 12: command packet length in bytes.

Ports:
- `clk` in 1: single clock; all logic is on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `uart_start` in 1: a rising edge requests a command transmit.
- `cmd_buf` in 8*`CMD_BYTES`: command bytes; byte k is bits [8k+7:8k].
- `tx_data` out 8: byte to the UART transmitter.
- `tx_valid` out 1: `tx_data` is valid.
- `tx_ready` in 1: the transmitter accepts the byte this cycle.
- `rx_data` in 8: byte from the UART receiver.
- `rx_valid` in 1: one-cycle strobe for `rx_data`; there is no backpressure.
- `reset_bytes_transmitted` in 1: clears the receive count and the write pointer.
- `bytes_in` out 16: number of bytes stored since the last clear.
- `read_addr` in 16: word read address; only bits [`ADDR_W`-1:0] are used.
- `buffer_read` in 1: read enable.
- `word_in` out 16: registered read data.
- `busy` out 1: a command transmit is in progress.
- `overflow` out 1: sticky; a received byte was dropped.

## Operation
- Reset: `tx_data`=0, `tx_valid`=0, `busy`=0, `bytes_in`=0, `word_in`=0, `overflow`=0, and the TX FSM goes to IDLE. RAM contents are not reset.
- Edge detect: `start_edge` = `uart_start` & ~`uart_start_q`, where `uart_start_q` is registered.
- TX FSM, IDLE:
  - On `start_edge`, latch `cmd_buf` into a shadow register, set idx=0, set `busy`=1, and go to SEND.
  - `start_edge` while in SEND or DONE is ignored.
- TX FSM, SEND:
  - `tx_valid`=1 and `tx_data`=shadow byte idx.
  - Byte 0 is `cmd_buf[7:0]` and is sent first.
  - On `tx_valid`&`tx_ready`:
    - If idx=`CMD_BYTES`-1, go to DONE with `tx_valid`=0.
    - Otherwise increment idx; the next byte is presented in the following cycle.
  - `tx_data` and `tx_valid` stay stable while `tx_ready`=0.
- TX FSM, DONE: `busy`=0, then go to IDLE.
- Receive path (always active, independent of the TX FSM):
  - Each `rx_valid` byte is written to byte offset b = `bytes_in`.
  - The byte goes into word b>>1: even b writes `{rx_data, 8'h00}`; odd b writes `{hold_hi, rx_data}`.
  - `hold_hi` holds the last even-offset byte.
  - Each stored byte increments `bytes_in`.
- Full condition: at `bytes_in`=16'hFFFF a further `rx_valid` byte is dropped, `overflow` is set, and `bytes_in` holds. The write pointer never wraps.
- Clear: on `reset_bytes_transmitted`=1, `bytes_in` goes to 0 and `overflow` goes to 0.
  - If `rx_valid` is high in the same cycle, the byte is stored at offset 0 and `bytes_in`=1.
- Read port:
  - On `buffer_read`=1, `word_in` takes RAM[`read_addr`[`ADDR_W`-1:0]] at the next edge.
  - `word_in` holds its value while `buffer_read`=0.
- Read-during-write to the same word returns the old contents.
- A byte is stored in RAM at the clock edge where `rx_valid` is sampled. A read issued in the following cycle returns it.

## Timing
- `uart_start` rising at edge N: `start_edge` at N+1, `busy` and `tx_valid` high after edge N+2.
- The transmit takes exactly `CMD_BYTES` handshakes. With `tx_ready` tied high, `tx_valid` is high for 12 consecutive cycles and `busy` falls one cycle after the last handshake.
- `rx_valid` sampled at edge N: `bytes_in` updated after edge N; a `buffer_read` at edge N+1 gives `word_in` after edge N+1.
- Read latency is 1 cycle from `buffer_read` to `word_in`.
- Reset asserted mid-transmit aborts at once: `tx_valid`=0 and the FSM is in IDLE. No partial resume.
- The TX and RX paths are fully concurrent; simultaneous events on both paths are handled without stalls.

## Test plan
- `cmd_buf` = bytes 0x70,0x01..0x0B, pulse `uart_start`, `tx_ready`=1 -> `tx_data` sequence 70,01..0B, 12 handshakes, `busy` high 12 cycles then 0.
- Same stimulus with `tx_ready` toggling 1-of-3 cycles -> identical byte order, `tx_data` stable while stalled, second `uart_start` pulse mid-transmit ignored.
- Receive 0xBA,0x06,0x0D,0xCA -> `bytes_in`=4; read addr 0 -> `word_in`=16'hBA06; read addr 1 -> 16'h0DCA.
- Receive 3 bytes 0x11,0x22,0x33 -> addr 1 reads 16'h3300; `reset_bytes_transmitted` concurrent with `rx_valid` of 0x44 -> `bytes_in`=1, addr 0 reads 16'h4400.
- Drive 65536 bytes -> `bytes_in`=16'hFFFF, `overflow`=1, and the last byte is not stored; `reset_bytes_transmitted` -> `bytes_in`=0, `overflow`=0.
- Assert `reset` low during SEND and during a read -> all outputs at their reset values at once, with no clock edge needed; after release a new `uart_start` sends from byte 0.
